// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default sizes for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned DEF_PC_W     = 8;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/ack bus and decode valid/ready handshake.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W    = DEF_PC_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;

  // Fetch sequencer side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  // Memory and decode side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, keeps one imem request in flight and
// hands each fetched word to decode over valid/ready.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned INSTR_W  = DEF_INSTR_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  fetch_sequencer_if.master bus,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic [CNT_W-1:0]  retired_cnt
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               squash_q, squash_d;
  logic [PC_W-1:0]    squash_addr_q, squash_addr_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] data_q, data_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  assign accept = valid_q & bus.instr_ready;

  // State register; reset beats every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= PC_W'(RESET_PC);
      squash_q      <= 1'b0;
      squash_addr_q <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      ipc_q         <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      squash_addr_q <= squash_addr_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
      ipc_q         <= ipc_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state: FSM, PC update, output holding register and retire counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    squash_addr_d = squash_addr_q;
    valid_d       = valid_q;
    data_d        = data_q;
    ipc_d         = ipc_q;
    cnt_d         = cnt_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (bus.imem_ack) begin
          if (squash_q || redirect_valid) begin
            // Response belongs to a stale request; refetch from the current pc.
            squash_d = 1'b0;
          end else begin
            data_d  = bus.imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
            state_d = StIssue;
          end
        end else if (redirect_valid && !squash_q) begin
          // Keep the outstanding request's address stable until it completes.
          squash_d      = 1'b1;
          squash_addr_d = pc_q;
        end
      end
      StIssue: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          state_d = (accept && halt) ? StHalt : StFetch;
        end else if (accept) begin
          valid_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = halt ? StHalt : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
    if (redirect_valid) pc_d = redirect_pc;
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.imem_req    = (state_q == StFetch);
    bus.imem_addr   = '0;
    if (state_q == StFetch) bus.imem_addr = squash_q ? squash_addr_q : pc_q;
    bus.instr_valid = valid_q;
    bus.instr_data  = data_q;
    bus.instr_pc    = ipc_q;
    pc              = pc_q;
    busy            = (state_q == StFetch) || (state_q == StIssue);
    retired_cnt     = cnt_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed sequences, a vector table
// and randomized traffic against a transaction-level reference model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             halt;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic [CNT_W-1:0] retired_cnt;

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_sequencer #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus(bus),
    .pc(pc), .busy(busy), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory responder controls.
  bit mem_auto = 1'b0;
  bit mem_rand = 1'b0;
  int mem_lat  = 0;
  int mem_wait = 0;

  typedef struct {
    logic [7:0] target;
    int         lat;
    logic [7:0] exp_pc;
    logic [7:0] exp_next;
  } vec_t;
  vec_t vecs[4];

  // Random-phase model state.
  bit         m_run;
  logic [7:0] m_next;
  int         m_cnt;
  bit         s, h, r, rst, rdy, acc, pend;
  logic [7:0] rt, paddr;
  int         n_acc;
  logic [3:0] cnt_before;

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle, then let the memory model decide this cycle's ack.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (bus.imem_req) begin
        if (mem_wait >= mem_lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = word_of(bus.imem_addr);
          mem_wait       = 0;
          if (mem_rand) mem_lat = $urandom_range(0, 3);
        end else begin
          bus.imem_ack = 1'b0;
          mem_wait++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        mem_wait     = 0;
      end
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 30; i++) begin
      if (bus.instr_valid) break;
      tick();
    end
    tests++;
    if (!bus.instr_valid) begin
      fails++;
      $display("FAIL %s: instr_valid still 0 after 30 cycles, want 1", name);
    end
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 30; i++) begin
      if (bus.imem_req) break;
      tick();
    end
    tests++;
    if (!bus.imem_req) begin
      fails++;
      $display("FAIL %s: imem_req still 0 after 30 cycles, want 1", name);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    tick();
    reset = 1'b0;
    mem_wait = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    vecs[0] = '{8'hFF, 0, 8'hFF, 8'h00};
    vecs[1] = '{8'h00, 1, 8'h00, 8'h01};
    vecs[2] = '{8'h7F, 2, 8'h7F, 8'h80};
    vecs[3] = '{8'h40, 3, 8'h40, 8'h41};

    tick(); tick();
    reset = 1'b0;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_cnt", 32'(retired_cnt), 32'h0);

    // Sequential fetch, ack one cycle after req, decode always ready.
    mem_auto = 1'b1; mem_lat = 1; bus.instr_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("t1_req_latency", 32'(bus.imem_req), 32'h1);
    for (int k = 0; k < 3; k++) begin
      wait_req("t1_req");
      check("t1_addr", 32'(bus.imem_addr), 32'(k));
      wait_valid("t1_valid");
      check("t1_ipc", 32'(bus.instr_pc), 32'(k));
      check("t1_data", bus.instr_data, word_of(8'(k)));
      tick();
    end
    check("t1_cnt", 32'(retired_cnt), 32'h3);

    // Decode stalls for 5 cycles.
    bus.instr_ready = 1'b0;
    wait_valid("t2_valid");
    for (int k = 0; k < 5; k++) begin
      check("t2_hold_valid", 32'(bus.instr_valid), 32'h1);
      check("t2_hold_ipc", 32'(bus.instr_pc), 32'h3);
      check("t2_hold_data", bus.instr_data, word_of(8'h03));
      check("t2_no_req", 32'(bus.imem_req), 32'h0);
      tick();
    end
    bus.instr_ready = 1'b1;
    tick();
    check("t2_req_after", 32'(bus.imem_req), 32'h1);
    check("t2_addr_after", 32'(bus.imem_addr), 32'h4);
    check("t2_cnt", 32'(retired_cnt), 32'h4);

    // Halt on accept of pc 5, restart, then redirect while in ISSUE.
    wait_valid("t5_v4");
    check("t5_ipc4", 32'(bus.instr_pc), 32'h4);
    tick();
    wait_valid("t5_v5");
    check("t5_ipc5", 32'(bus.instr_pc), 32'h5);
    halt = 1'b1; tick(); halt = 1'b0;
    check("t5_halt_busy", 32'(busy), 32'h0);
    check("t5_halt_req", 32'(bus.imem_req), 32'h0);
    check("t5_halt_cnt", 32'(retired_cnt), 32'h6);
    check("t5_halt_pc", 32'(pc), 32'h6);
    tick(); tick(); tick();
    check("t5_halt_stays", 32'(busy), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_restart_req", 32'(bus.imem_req), 32'h1);
    check("t5_restart_addr", 32'(bus.imem_addr), 32'h6);
    bus.instr_ready = 1'b0;
    wait_valid("t5_v6");
    check("t5_ipc6", 32'(bus.instr_pc), 32'h6);
    redirect_valid = 1'b1; redirect_pc = 8'h20; tick(); redirect_valid = 1'b0;
    check("t5_redir_valid", 32'(bus.instr_valid), 32'h0);
    check("t5_redir_cnt", 32'(retired_cnt), 32'h6);
    check("t5_redir_pc", 32'(pc), 32'h20);
    check("t5_redir_addr", 32'(bus.imem_addr), 32'h20);
    bus.instr_ready = 1'b1;

    // Redirect+start from IDLE into varied targets, including the 0xFF wrap.
    foreach (vecs[i]) begin
      do_reset();
      mem_lat = vecs[i].lat; bus.instr_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = vecs[i].target; start = 1'b1;
      tick();
      redirect_valid = 1'b0; start = 1'b0;
      check("tv_req", 32'(bus.imem_req), 32'h1);
      check("tv_addr", 32'(bus.imem_addr), 32'(vecs[i].exp_pc));
      wait_valid("tv_valid");
      check("tv_ipc", 32'(bus.instr_pc), 32'(vecs[i].exp_pc));
      check("tv_data", bus.instr_data, word_of(vecs[i].exp_pc));
      tick();
      check("tv_pc_next", 32'(pc), 32'(vecs[i].exp_next));
      check("tv_addr_next", 32'(bus.imem_addr), 32'(vecs[i].exp_next));
    end

    // Zero-wait memory: one accept every two cycles; counter saturates.
    mem_lat = 0;
    wait_valid("tz_valid");
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.instr_valid && bus.instr_ready) n_acc++;
      tick();
    end
    check("tz_accepts_in_8", 32'(n_acc), 32'h4);
    for (int k = 0; k < 40; k++) tick();
    check("tz_cnt_saturated", 32'(retired_cnt), 32'hF);

    // Delayed ack with redirect while the request is outstanding.
    do_reset();
    mem_auto = 1'b0; bus.instr_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    check("t4_req", 32'(bus.imem_req), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 8'h40; tick(); redirect_valid = 1'b0;
    check("t4_addr_stable", 32'(bus.imem_addr), 32'h0);
    check("t4_pc", 32'(pc), 32'h40);
    tick();
    check("t4_addr_stable2", 32'(bus.imem_addr), 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = word_of(8'h00); tick(); bus.imem_ack = 1'b0;
    check("t4_stale_dropped", 32'(bus.instr_valid), 32'h0);
    check("t4_req_again", 32'(bus.imem_req), 32'h1);
    check("t4_addr_new", 32'(bus.imem_addr), 32'h40);
    bus.imem_ack = 1'b1; bus.imem_rdata = word_of(8'h40); tick(); bus.imem_ack = 1'b0;
    check("t4_valid", 32'(bus.instr_valid), 32'h1);
    check("t4_ipc", 32'(bus.instr_pc), 32'h40);
    tick();
    // Redirect coinciding with ack discards the returned word.
    bus.imem_ack = 1'b1; bus.imem_rdata = word_of(8'h41);
    redirect_valid = 1'b1; redirect_pc = 8'h90; tick();
    bus.imem_ack = 1'b0; redirect_valid = 1'b0;
    check("t4_ackredir_valid", 32'(bus.instr_valid), 32'h0);
    check("t4_ackredir_addr", 32'(bus.imem_addr), 32'h90);

    // Reset in ISSUE, reset in FETCH, stray ack afterwards.
    bus.imem_ack = 1'b1; bus.imem_rdata = word_of(8'h90); tick(); bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0; tick();
    check("t6_in_issue", 32'(bus.instr_valid), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_issue_pc", 32'(pc), 32'h0);
    check("t6_issue_valid", 32'(bus.instr_valid), 32'h0);
    check("t6_issue_req", 32'(bus.imem_req), 32'h0);
    check("t6_issue_cnt", 32'(retired_cnt), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    check("t6_fetch_req", 32'(bus.imem_req), 32'h1);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    check("t6_fetch_req_rst", 32'(bus.imem_req), 32'h0);
    check("t6_fetch_busy", 32'(busy), 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = word_of(8'h77); tick(); bus.imem_ack = 1'b0;
    check("t6_late_ack_valid", 32'(bus.instr_valid), 32'h0);
    check("t6_late_ack_busy", 32'(busy), 32'h0);
    check("t6_late_ack_pc", 32'(pc), 32'h0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    mem_auto = 1'b1; mem_rand = 1'b1; mem_lat = 1;
    m_run = 1'b0; m_next = 8'h00; m_cnt = 0;
    for (int it = 0; it < 3000; it++) begin
      s   = ($urandom_range(0, 7) == 0);
      h   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 15) == 0);
      rt  = 8'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      start = s; halt = h; redirect_valid = r; redirect_pc = rt; reset = rst;
      bus.instr_ready = rdy;
      acc   = bus.instr_valid && rdy;
      pend  = bus.imem_req && !bus.imem_ack;
      paddr = bus.imem_addr;
      if (rst) begin
        m_run = 1'b0; m_next = 8'h00; m_cnt = 0;
      end else begin
        if (acc && !r) begin
          check("rnd_ipc", 32'(bus.instr_pc), 32'(m_next));
          check("rnd_data", bus.instr_data, word_of(m_next));
          m_next = m_next + 8'h01;
          if (m_cnt < 15) m_cnt++;
        end
        if (acc && h) m_run = 1'b0;
        else if (s && !m_run) m_run = 1'b1;
        if (r) m_next = rt;
      end
      tick();
      check("rnd_busy", 32'(busy), 32'(m_run));
      check("rnd_cnt", 32'(retired_cnt), 32'(m_cnt));
      if (!m_run) begin
        check("rnd_idle_req", 32'(bus.imem_req), 32'h0);
        check("rnd_idle_valid", 32'(bus.instr_valid), 32'h0);
        check("rnd_idle_pc", 32'(pc), 32'(m_next));
      end
      if (pend && !rst && bus.imem_req) check("rnd_addr_stable", 32'(bus.imem_addr), 32'(paddr));
    end
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
